pipelined_cla_adder: RTL and testbench

Parametrised, pipelined carry-lookahead adder/subtractor. Operands are split into BLOCK-bit groups; each group is one pipeline stage with an internal lookahead carry. The carry between groups is registered, giving one result per cycle at a latency of WIDTH/BLOCK cycles. Valid/ready handshakes on both sides let it sit in a streaming datapath; it generalises the team's fixed 8-bit hybrid ripple/CLA adder.

---
 rtl/pipelined_cla_adder_if.sv | 26 ++
 rtl/pipelined_cla_adder.sv | 130 +++++++++++++
 tb/tb_pipelined_cla_adder.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/pipelined_cla_adder_if.sv
// rtl/pipelined_cla_adder_if.sv - operand/result handshake bundle for pipelined_cla_adder
interface pipelined_cla_adder_if #(
  parameter int WIDTH = 16
);
  logic             IN_VALID;
  logic             IN_READY;
  logic [WIDTH-1:0] X;
  logic [WIDTH-1:0] Y;
  logic             C0;
  logic             SUB;
  logic             OUT_VALID;
  logic             OUT_READY;
  logic [WIDTH-1:0] S;
  logic             CO;
  logic             OVF;

  modport master (
    output IN_VALID, X, Y, C0, SUB, OUT_READY,
    input  IN_READY, OUT_VALID, S, CO, OVF
  );

  modport slave (
    input  IN_VALID, X, Y, C0, SUB, OUT_READY,
    output IN_READY, OUT_VALID, S, CO, OVF
  );
endinterface

// File: rtl/pipelined_cla_adder.sv
// rtl/pipelined_cla_adder.sv - pipelined carry-lookahead add/sub, one BLOCK-bit group per stage
// Optional signed saturation of S on overflow when CLA_SAT_EN is defined.
module pipelined_cla_adder #(
  parameter int WIDTH = 16,
  parameter int BLOCK = 4
) (
  input logic                  CLK,
  input logic                  RST_N,
  pipelined_cla_adder_if.slave bus
);
  localparam int STAGES = WIDTH / BLOCK;

  if (BLOCK < 1 || BLOCK > 8 || (WIDTH % BLOCK) != 0) begin : g_param_check
    $error("pipelined_cla_adder: WIDTH must be a multiple of BLOCK, BLOCK in 1..8");
  end

  logic             advance;
  logic [WIDTH-1:0] y_eff;

  assign advance      = !bus.OUT_VALID || bus.OUT_READY;
  assign bus.IN_READY = advance;
  assign y_eff        = bus.SUB ? ~bus.Y : bus.Y;

  // Every carry is a flat sum of products from the group carry-in, no rippling.
  function automatic logic [BLOCK:0] lookahead(input logic [BLOCK-1:0] pp,
                                                input logic [BLOCK-1:0] gg,
                                                input logic             cin);
    logic [BLOCK:0] cc;
    logic           term;
    cc    = '0;
    cc[0] = cin;
    for (int i = 1; i <= BLOCK; i++) begin
      term = cin;
      for (int j = 0; j < i; j++) term = term & pp[j];
      cc[i] = term;
      for (int j = 0; j < i; j++) begin
        term = gg[j];
        for (int m = j + 1; m < i; m++) term = term & pp[m];
        cc[i] = cc[i] | term;
      end
    end
    return cc;
  endfunction

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    localparam int LO  = k * BLOCK;
    localparam int HI  = LO + BLOCK;
    localparam int REM = WIDTH - HI;

    logic [BLOCK-1:0] gx, gy, p, g, grp_sum;
    logic [BLOCK:0]   c;
    logic             cin, vin;
    logic [HI-1:0]    s_raw, s_d, s_q;
    logic             vld_q, c_q;

    if (k == 0) begin : g_src
      assign gx    = bus.X[BLOCK-1:0];
      assign gy    = y_eff[BLOCK-1:0];
      assign cin   = bus.SUB | bus.C0;
      assign vin   = bus.IN_VALID;
      assign s_raw = grp_sum;
    end else begin : g_src
      assign gx    = g_stage[k-1].g_skew.x_q[BLOCK-1:0];
      assign gy    = g_stage[k-1].g_skew.y_q[BLOCK-1:0];
      assign cin   = g_stage[k-1].c_q;
      assign vin   = g_stage[k-1].vld_q;
      assign s_raw = {grp_sum, g_stage[k-1].s_q};
    end

    assign p       = gx ^ gy;
    assign g       = gx & gy;
    assign c       = lookahead(p, g, cin);
    assign grp_sum = p ^ c[BLOCK-1:0];

    // Higher operand groups ride along until their stage sees the carry.
    if (REM > 0) begin : g_skew
      logic [REM-1:0] x_d, y_d, x_q, y_q;
      if (k == 0) begin : g_fwd
        assign x_d = bus.X[WIDTH-1:BLOCK];
        assign y_d = y_eff[WIDTH-1:BLOCK];
      end else begin : g_fwd
        assign x_d = g_stage[k-1].g_skew.x_q[REM+BLOCK-1:BLOCK];
        assign y_d = g_stage[k-1].g_skew.y_q[REM+BLOCK-1:BLOCK];
      end
      always_ff @(posedge CLK) begin
        if (!RST_N) begin
          x_q <= '0;
          y_q <= '0;
        end else if (advance) begin
          x_q <= x_d;
          y_q <= y_d;
        end
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic ovf, ovf_q;
      assign ovf = c[BLOCK] ^ c[BLOCK-1];
`ifdef CLA_SAT_EN
      assign s_d = !ovf ? s_raw :
                   (s_raw[HI-1] ? {1'b0, {(HI-1){1'b1}}} : {1'b1, {(HI-1){1'b0}}});
`else
      assign s_d = s_raw;
`endif
      always_ff @(posedge CLK) begin
        if (!RST_N)       ovf_q <= 1'b0;
        else if (advance) ovf_q <= ovf;
      end
    end else begin : g_mid
      assign s_d = s_raw;
    end

    always_ff @(posedge CLK) begin
      if (!RST_N) begin
        vld_q <= 1'b0;
        s_q   <= '0;
        c_q   <= 1'b0;
      end else if (advance) begin
        vld_q <= vin;
        s_q   <= s_d;
        c_q   <= c[BLOCK];
      end
    end
  end

  assign bus.OUT_VALID = g_stage[STAGES-1].vld_q;
  assign bus.S         = g_stage[STAGES-1].s_q;
  assign bus.CO        = g_stage[STAGES-1].c_q;
  assign bus.OVF       = g_stage[STAGES-1].g_last.ovf_q;
endmodule

// File: tb/tb_pipelined_cla_adder.sv
// tb/tb_pipelined_cla_adder.sv - self-checking bench for pipelined_cla_adder (16-bit, 4-bit groups)
module tb_pipelined_cla_adder;
  localparam int WIDTH  = 16;
  localparam int BLOCK  = 4;
  localparam int STAGES = WIDTH / BLOCK;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        c0;
    logic        sub;
    logic [15:0] s;
    logic        co;
    logic        ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;
  logic last_accept = 1'b0;
  vec_t pending;
  vec_t q[$];
  vec_t tbl[12];

  pipelined_cla_adder_if #(.WIDTH(WIDTH)) bus ();

  pipelined_cla_adder #(.WIDTH(WIDTH), .BLOCK(BLOCK)) dut (
    .CLK  (clk),
    .RST_N(rst_n),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s actual=%h required=%h", name, act, req);
    end
  endtask

  // Reference: plain integer add, overflow from operand/result signs.
  function automatic vec_t model(input logic [15:0] x, input logic [15:0] y,
                                 input logic c0, input logic sub);
    vec_t        r;
    logic [15:0] b;
    logic [16:0] sum;
    b     = sub ? ~y : y;
    sum   = {1'b0, x} + {1'b0, b} + (sub ? 17'd1 : {16'd0, c0});
    r.x   = x;
    r.y   = y;
    r.c0  = c0;
    r.sub = sub;
    r.s   = sum[15:0];
    r.co  = sum[16];
    r.ovf = (x[15] == b[15]) && (sum[15] != x[15]);
`ifdef CLA_SAT_EN
    if (r.ovf) r.s = sum[15] ? 16'h7FFF : 16'h8000;
`endif
    return r;
  endfunction

  function automatic logic [15:0] pick_operand();
    case ($urandom_range(0, 7))
      0:       return 16'hFFFF;
      1:       return 16'h8000;
      2:       return 16'h7FFF;
      3:       return 16'h0000;
      default: return 16'($urandom);
    endcase
  endfunction

  function automatic vec_t rand_vec();
    return model(pick_operand(), pick_operand(), 1'($urandom), 1'($urandom));
  endfunction

  task automatic put(input vec_t v);
    bus.X        = v.x;
    bus.Y        = v.y;
    bus.C0       = v.c0;
    bus.SUB      = v.sub;
    pending      = v;
    bus.IN_VALID = 1'b1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: outputs and handshakes are settled at the falling edge and hold until the next rising edge.
  always @(negedge clk) begin
    vec_t e;
    last_accept = 1'b0;
    if (!rst_n) begin
      q.delete();
    end else begin
      if (bus.OUT_VALID && bus.OUT_READY) begin
        if (q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_out actual S=%h required no result", bus.S);
        end else begin
          e = q.pop_front();
          check("out_s", 32'(bus.S), 32'(e.s));
          check("out_co", 32'(bus.CO), 32'(e.co));
          check("out_ovf", 32'(bus.OVF), 32'(e.ovf));
        end
      end
      if (bus.IN_VALID && bus.IN_READY) begin
        q.push_back(pending);
        last_accept = 1'b1;
      end
    end
  end

  task automatic latency_beat(input vec_t v);
    put(v);
    tick();
    check("lat_accept", 32'(last_accept), 32'd1);
    bus.IN_VALID = 1'b0;
    for (int c = 1; c < STAGES; c++) begin
      tick();
      check("lat_valid", 32'(bus.OUT_VALID), 32'(c == STAGES - 1));
    end
    tick();
  endtask

  initial begin
    tbl[0]  = '{16'h00FF, 16'h0001, 1'b0, 1'b0, 16'h0100, 1'b0, 1'b0};
    tbl[1]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0};
`ifdef CLA_SAT_EN
    tbl[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h7FFF, 1'b0, 1'b1};
    tbl[4]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h8000, 1'b1, 1'b1};
    tbl[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h8000, 1'b1, 1'b1};
    tbl[11] = '{16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 16'h7FFF, 1'b0, 1'b1};
`else
    tbl[2]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[4]  = '{16'h8000, 16'h0001, 1'b1, 1'b1, 16'h7FFF, 1'b1, 1'b1};
    tbl[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[11] = '{16'h7FFF, 16'h7FFF, 1'b1, 1'b0, 16'hFFFF, 1'b0, 1'b1};
`endif
    tbl[3]  = '{16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[5]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0};
    tbl[7]  = '{16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0};
    tbl[8]  = '{16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0};
    tbl[9]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0};
    tbl[10] = '{16'h0000, 16'h0000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0};

    rst_n         = 1'b0;
    bus.IN_VALID  = 1'b1;
    bus.X         = 16'h1234;
    bus.Y         = 16'h0000;
    bus.C0        = 1'b0;
    bus.SUB       = 1'b0;
    bus.OUT_READY = 1'b1;
    pending       = model(16'h1234, 16'h0000, 1'b0, 1'b0);

    repeat (2) begin
      tick();
      check("rst_out_valid", 32'(bus.OUT_VALID), 32'd0);
      check("rst_s", 32'(bus.S), 32'd0);
      check("rst_co", 32'(bus.CO), 32'd0);
      check("rst_ovf", 32'(bus.OVF), 32'd0);
    end
    rst_n        = 1'b1;
    bus.IN_VALID = 1'b0;
    repeat (8) tick();

    latency_beat(tbl[0]);
    repeat (2) tick();

    for (int i = 0; i < 12; i++) begin
      put(tbl[i]);
      tick();
      check("stream_accept", 32'(last_accept), 32'd1);
    end
    bus.IN_VALID = 1'b0;
    repeat (STAGES - 1) tick();
    check("stream_tail_pending", 32'(q.size()), 32'd1);
    tick();
    check("stream_drained", 32'(q.size()), 32'd0);

    bus.OUT_READY = 1'b0;
    put(rand_vec());
    for (int c = 0; c < 10; c++) begin
      tick();
      if (last_accept) put(rand_vec());
      if (!bus.IN_READY) break;
    end
    check("stall_full_in_ready", 32'(bus.IN_READY), 32'd0);
    check("stall_in_flight", 32'(q.size()), 32'(STAGES));
    repeat (3) begin
      tick();
      check("stall_in_ready", 32'(bus.IN_READY), 32'd0);
      check("stall_out_valid", 32'(bus.OUT_VALID), 32'd1);
      if (q.size() > 0) begin
        check("stall_s", 32'(bus.S), 32'(q[0].s));
        check("stall_co", 32'(bus.CO), 32'(q[0].co));
        check("stall_ovf", 32'(bus.OVF), 32'(q[0].ovf));
      end
    end
    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b1;
    repeat (STAGES) tick();
    check("stall_drained", 32'(q.size()), 32'd0);

    for (int i = 0; i < 3; i++) begin
      put(rand_vec());
      tick();
    end
    rst_n        = 1'b0;
    bus.IN_VALID = 1'b0;
    tick();
    check("midrst_out_valid", 32'(bus.OUT_VALID), 32'd0);
    rst_n = 1'b1;
    repeat (6) tick();
    latency_beat('{16'h0001, 16'h0001, 1'b0, 1'b0, 16'h0002, 1'b0, 1'b0});

    bus.IN_VALID = 1'b0;
    for (int c = 0; c < 600; c++) begin
      if (!bus.IN_VALID || last_accept) begin
        if ($urandom_range(0, 3) != 0) put(rand_vec());
        else bus.IN_VALID = 1'b0;
      end
      bus.OUT_READY = ($urandom_range(0, 3) != 0);
      tick();
    end
    bus.IN_VALID  = 1'b0;
    bus.OUT_READY = 1'b1;
    for (int c = 0; c < 20 && q.size() > 0; c++) tick();
    check("random_drained", 32'(q.size()), 32'd0);
    repeat (4) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
